ringosc_freq_meter: RTL and testbench

RINGOSC_FREQ_METER -- requirements
Module: ringosc_freq_meter

---
 rtl/ringosc_pkg.sv | 24 ++
 rtl/ringosc_channel.sv | 69 ++++++
 rtl/ringosc_freq_meter.sv | 189 ++++++++++++++++++
 tb/tb_ringosc_freq_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ringosc_pkg.sv
// ----------------------------------------------------------------------------
// ringosc_pkg
// Shared definitions for the ring-oscillator frequency meter: default
// parameter values and the measurement FSM state encoding.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package ringosc_pkg;

    localparam int DEF_NUM_RINGS     = 4;   // ring channels
    localparam int DEF_RING_LENGTH   = 5;   // inverting stages in channel 0
    localparam int DEF_PRESCALE_BITS = 8;   // ripple divider stages
    localparam int DEF_WINDOW_LOG2   = 12;  // gate window = 2**WINDOW_LOG2 clk cycles
    localparam int DEF_COUNT_WIDTH   = 16;  // result width
    localparam int DEF_SETTLE_CYCLES = 16;  // ring/divider settle time in clk cycles

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_e;

endpackage

// File: rtl/ringosc_channel.sv
// ----------------------------------------------------------------------------
// ringosc_channel
// One gated ring oscillator followed by a ripple-counter prescaler.
// The ring is a NAND (enable gate, one inverting stage) plus RING_STAGES-1
// inverters, so RING_STAGES must be odd.  With en low the NAND output is
// forced high and the ring is static.  The ring output clocks a chain of
// toggle flops; each flop is clocked by the previous stage's output.
//
// Ports
//   rst  : asynchronous active-high clear of the divider flops
//   en   : ring enable (NAND gate input)
//   tap  : divider MSB (ring frequency / 2**PRESCALE_BITS), unsynchronised
//
// Outside synthesis every gate is a behavioural model with a one-unit delay,
// which gives the ring a finite, predictable period (2 * RING_STAGES units).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifdef SYNTHESIS
`define RINGOSC_GATE_DLY
`else
`define RINGOSC_GATE_DLY #1
`endif

module ringosc_channel #(
    parameter int RING_STAGES   = 5,
    parameter int PRESCALE_BITS = 8
) (
    input  logic rst,
    input  logic en,
    output logic tap
);

    // Ring nodes are kept so synthesis cannot collapse the loop.
    (* keep = "true", syn_keep = 1 *) logic [RING_STAGES-1:0] ring_n;

    // div_clk[i] clocks divider stage i; div_clk[PRESCALE_BITS] is the MSB.
    logic [PRESCALE_BITS:0] div_clk;

    assign `RINGOSC_GATE_DLY ring_n[0] = ~(en & ring_n[RING_STAGES-1]);

    for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
        assign `RINGOSC_GATE_DLY ring_n[i] = ~ring_n[i-1];
    end

    assign div_clk[0] = ring_n[RING_STAGES-1];

    for (genvar i = 0; i < PRESCALE_BITS; i++) begin : g_div
        (* keep = "true", syn_keep = 1 *) logic q;
        (* keep = "true", syn_keep = 1 *) logic d;

        assign `RINGOSC_GATE_DLY d = ~q;

        always_ff @(posedge div_clk[i] or posedge rst) begin
            if (rst) begin
                q <= 1'b0;
            end else begin
                q <= d;
            end
        end

        assign div_clk[i+1] = q;
    end

    assign tap = div_clk[PRESCALE_BITS];

endmodule

`undef RINGOSC_GATE_DLY

// File: rtl/ringosc_freq_meter.sv
// ----------------------------------------------------------------------------
// ringosc_freq_meter
// Measures the frequency of one of NUM_RINGS on-chip ring oscillators by
// counting prescaled ring edges over a fixed window of clk cycles.
//
// Ports
//   clk          : reference clock (rising edge)
//   rst          : asynchronous active-high reset
//   ena          : master enable; low aborts any measurement and stops rings
//   sel          : channel to measure (latched on an accepted start)
//   start        : measurement request, accepted only in IDLE with ena high
//   continuous   : 1 = back-to-back windows, 0 = single shot (latched on start)
//   ack          : clears result_valid (a coincident result update wins)
//   busy         : FSM not in IDLE
//   result_valid : result holds an unacknowledged measurement
//   result       : prescaled edge count of the last completed window
//   overflow     : last completed window saturated the counter
//   ring_tap     : divider MSB of the latched channel, unsynchronised
//
// Timing: start accepted at edge t -> SETTLE for SETTLE_CYCLES, MEASURE for
// 2**WINDOW_LOG2 cycles, DONE for one cycle; result_valid rises at edge
// t + SETTLE_CYCLES + 2**WINDOW_LOG2 + 1.  In continuous mode DONE returns
// straight to MEASURE, so results update every 2**WINDOW_LOG2 + 1 cycles.
// While busy, continuous can only be withdrawn: dropping it lets the current
// window finish and then stops; raising it has no effect until the next start.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ringosc_freq_meter
    import ringosc_pkg::*;
#(
    parameter int NUM_RINGS     = DEF_NUM_RINGS,
    parameter int RING_LENGTH   = DEF_RING_LENGTH,
    parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
    parameter int WINDOW_LOG2   = DEF_WINDOW_LOG2,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [$clog2(NUM_RINGS)-1:0] sel,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         ack,
    output logic                         busy,
    output logic                         result_valid,
    output logic [COUNT_WIDTH-1:0]       result,
    output logic                         overflow,
    output logic                         ring_tap
);

    localparam int SEL_W   = $clog2(NUM_RINGS);
    localparam int TIMER_W = WINDOW_LOG2;
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);

    meter_state_e           state_q, state_d;
    logic                   accept, publish;
    logic [SEL_W-1:0]       sel_q;
    logic                   cont_q;
    logic [TIMER_W-1:0]     timer_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   sat_q;
    logic [NUM_RINGS-1:0]   ring_en, ring_taps;
    logic [1:0]             sync_q;
    logic                   tap_prev_q;
    logic                   tap_rise;

    // ------------------------------------------------------------------
    // Ring channels: only the latched channel runs, and only while busy.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RINGS; k++) begin : g_ch
        assign ring_en[k] = busy && (sel_q == SEL_W'(k));

        ringosc_channel #(
            .RING_STAGES  (RING_LENGTH + 2 * k),
            .PRESCALE_BITS(PRESCALE_BITS)
        ) u_channel (
            .rst(rst),
            .en (ring_en[k]),
            .tap(ring_taps[k])
        );
    end

    assign ring_tap = ring_taps[sel_q];
    assign busy     = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the values from before this edge.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned
        // (which would infer a latch).
        state_d = state_q;
        accept  = 1'b0;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (timer_q == '1) state_d = ST_DONE;
            end
            ST_DONE: begin
                publish = 1'b1;
                state_d = (cont_q && ena) ? ST_MEASURE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!ena) state_d = ST_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath: phase timer, mode latch, edge synchroniser, counter, result
    // ------------------------------------------------------------------
    assign tap_rise = sync_q[1] & ~tap_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= '0;
            cont_q       <= 1'b0;
            timer_q      <= '0;
            sync_q       <= '0;
            tap_prev_q   <= 1'b0;
            count_q      <= '0;
            sat_q        <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (accept) begin
                sel_q  <= sel;
                cont_q <= continuous;
            end else if (busy) begin
                cont_q <= cont_q & continuous;
            end

            // Each phase starts its timer from zero.
            if (state_q == ST_IDLE || state_d != state_q) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            sync_q     <= {sync_q[0], ring_tap};
            tap_prev_q <= sync_q[1];

            // Outside MEASURE the count is held clear; DONE publishes the
            // finished count on the same edge that clears it.
            if (state_q == ST_MEASURE) begin
                if (tap_rise) begin
                    if (count_q == '1) begin
                        sat_q <= 1'b1;
                    end else begin
                        count_q <= count_q + COUNT_WIDTH'(1);
                    end
                end
            end else begin
                count_q <= '0;
                sat_q   <= 1'b0;
            end

            if (publish) begin
                result       <= count_q;
                overflow     <= sat_q;
                result_valid <= 1'b1;
            end else if (ack) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// ----------------------------------------------------------------------------
// tb_ringosc_freq_meter
// Directed bench for ringosc_freq_meter.  clk period 100 ns; each ring gate
// has a 1 ns model delay, so channel 0 (5 stages) runs at 10 ns and channel 1
// (7 stages) at 14 ns.  Expected counts over a 4096 x 100 ns window with a
// /256 prescaler: 409600 / 2560 = 160 and 409600 / 3584 = 114.3.
// A second instance uses COUNT_WIDTH=4 to exercise saturation.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ringosc_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  sel;
    logic        start, continuous, ack;
    logic        busy, result_valid, overflow, ring_tap;
    logic [15:0] result;

    logic [1:0]  sel2;
    logic        start2, cont2, ack2;
    logic        busy2, rv2, ovf2, tap2;
    logic [3:0]  result2;

    int checks = 0;
    int errors = 0;
    logic [31:0] saved;

    always #50 clk = ~clk;

    ringosc_freq_meter dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sel         (sel),
        .start       (start),
        .continuous  (continuous),
        .ack         (ack),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .overflow    (overflow),
        .ring_tap    (ring_tap)
    );

    ringosc_freq_meter #(.COUNT_WIDTH(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sel         (sel2),
        .start       (start2),
        .continuous  (cont2),
        .ack         (ack2),
        .busy        (busy2),
        .result_valid(rv2),
        .result      (result2),
        .overflow    (ovf2),
        .ring_tap    (tap2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] observed,
                               input logic [31:0] lo, input logic [31:0] hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; sel = 2'd0; start = 1'b0; continuous = 1'b0; ack = 1'b0;
        sel2 = 2'd0; start2 = 1'b0; cont2 = 1'b0; ack2 = 1'b0;

        // Reset state
        tick(2);
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_overflow", overflow, 0);
        check("reset_tap", ring_tap, 0);
        check("reset_busy_sat", busy2, 0);
        rst = 1'b0;
        tick(2);
        check("idle_after_reset", busy, 0);

        // Single shot, channel 0; a start while busy (with sel=1) is ignored
        sel = 2'd0; continuous = 1'b0; start = 1'b1;
        tick(1);                                   // edge t
        start = 1'b0;
        check("busy_after_start", busy, 1);
        tick(500);                                 // t+500
        sel = 2'd1; start = 1'b1;
        tick(1);                                   // t+501
        start = 1'b0; sel = 2'd0;
        check("busy_start_ignored", busy, 1);
        tick(3611);                                // t+4112
        check("valid_before_latency", result_valid, 0);
        check("busy_in_done", busy, 1);
        tick(1);                                   // t+4113
        check("valid_at_latency", result_valid, 1);
        check_range("result_sel0", result, 159, 161);
        check("overflow_sel0", overflow, 0);
        check("busy_fall_single", busy, 0);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_clears_valid", result_valid, 0);

        // Single shot, channel 1; raising continuous while busy has no effect
        sel = 2'd1; start = 1'b1;
        tick(1);                                   // edge t
        start = 1'b0;
        tick(100);
        continuous = 1'b1;
        tick(4013);                                // t+4113
        check("valid_sel1", result_valid, 1);
        check_range("result_sel1", result, 113, 115);
        check("overflow_sel1", overflow, 0);
        check("cont_raise_ignored", busy, 0);
        continuous = 1'b0;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_clears_valid_2", result_valid, 0);

        // Continuous mode on channel 0, no ack
        sel = 2'd0; continuous = 1'b1; start = 1'b1;
        tick(1);                                   // edge t
        start = 1'b0;
        tick(4112);                                // t+4112
        check("cont_valid_before", result_valid, 0);
        tick(1);                                   // t+4113
        check("cont_w1_valid", result_valid, 1);
        check_range("cont_w1_result", result, 159, 161);
        check("cont_w1_busy", busy, 1);
        saved = 32'(result);
        tick(4096);                                // t+8209
        check("cont_w1_hold", result, saved);
        check("cont_w1_valid_hold", result_valid, 1);
        tick(1);                                   // t+8210
        check_range("cont_w2_result", result, 159, 161);
        check("cont_w2_valid", result_valid, 1);
        check("cont_w2_busy", busy, 1);
        tick(4097);                                // t+12307
        check_range("cont_w3_result", result, 159, 161);
        check("cont_w3_valid", result_valid, 1);
        check("cont_w3_busy", busy, 1);
        continuous = 1'b0;
        tick(4096);                                // t+16403
        check("cont_stop_busy_done", busy, 1);
        tick(1);                                   // t+16404
        check("cont_stop_idle", busy, 0);
        check("cont_stop_valid", result_valid, 1);
        check_range("cont_w4_result", result, 159, 161);

        // ena dropped mid-MEASURE: abort, earlier result retained
        saved = 32'(result);
        sel = 2'd1; start = 1'b1;
        tick(1);                                   // edge t
        start = 1'b0;
        tick(300);
        check("ena_busy_before", busy, 1);
        ena = 1'b0;
        tick(1);
        check("ena_drop_idle", busy, 0);
        check("ena_drop_result", result, saved);
        check("ena_drop_valid", result_valid, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_without_ena", busy, 0);
        ena = 1'b1;
        tick(4200);
        check("ena_no_late_update", result, saved);

        // Asynchronous reset mid-MEASURE
        sel = 2'd0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(200);
        check("rst_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", result_valid, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_overflow", overflow, 0);
        check("rst_mid_tap", ring_tap, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rst_mid_idle", busy, 0);

        // COUNT_WIDTH=4: saturation, overflow, ack colliding with update
        sel2 = 2'd0; cont2 = 1'b0; start2 = 1'b1;
        tick(1);                                   // edge t
        start2 = 1'b0;
        tick(4112);                                // t+4112
        check("sat_valid_before", rv2, 0);
        ack2 = 1'b1;
        tick(1);                                   // t+4113, ack coincides with update
        ack2 = 1'b0;
        check("sat_ack_collision_valid", rv2, 1);
        check("sat_result", result2, 15);
        check("sat_overflow", ovf2, 1);
        check("sat_busy_fall", busy2, 0);
        ack2 = 1'b1;
        tick(1);
        ack2 = 1'b0;
        check("sat_ack_clears", rv2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
